// File: rtl/dmem_responder.sv
// Memory-side responder for a req/gnt/rvalid bus.
// Accepts word/byte-enable reads and writes on an internal word array and
// answers each accepted request in order after a fixed latency, with
// integrity bits on read data and an error flag.
//
// Handshake: a request is accepted on a rising edge where req_i && gnt_o.
// The requester holds addr_i/we_i/be_i/wdata_* stable until accepted.
// Each accepted request produces exactly one rvalid_o pulse RESP_DELAY
// cycles after the accepting edge; there is no back-pressure on responses.
module dmem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned GNT_DELAY       = 0,
    parameter int unsigned RESP_DELAY      = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  wdata_intg_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int HD = RESP_DELAY - 1;

    // Integrity: bit i is the XOR of every data bit j with j mod 7 == i.
    function automatic logic [6:0] intg(input logic [31:0] d);
        logic [6:0] r;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            r[j % 7] = r[j % 7] ^ d[j];
        end
        return r;
    endfunction

    logic [31:0] mem [MEM_WORDS];

    logic [1:0]    wait_cnt;
    logic [OW-1:0] outst;
    logic          accept;

    logic [31:0] word_off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        intg_ok;
    logic        do_write;
    logic        resp_err;
    logic [31:0] resp_data;

    logic [RESP_DELAY-1:0] pipe_v;
    logic [RESP_DELAY-1:0] pipe_e;
    logic [31:0]           pipe_d [RESP_DELAY];

    // Grant once the wait count has reached GNT_DELAY and there is room for
    // another outstanding response; a retiring response does not free a slot
    // until the following cycle.
    always_comb begin
        gnt_o  = req_i && (wait_cnt == 2'(GNT_DELAY)) &&
                 (outst < OW'(MAX_OUTSTANDING));
        accept = gnt_o;
    end

    // Address decode, write integrity check and response payload selection.
    always_comb begin
        word_off  = (addr_i - BASE_ADDR) >> 2;
        in_range  = (addr_i >= BASE_ADDR) && (word_off < MEM_WORDS);
        idx       = word_off[AW-1:0];
        intg_ok   = (wdata_intg_i == intg(wdata_i));
        do_write  = accept && we_i && in_range && intg_ok;
        resp_err  = we_i ? !(in_range && intg_ok) : !in_range;
        resp_data = (!we_i && in_range) ? mem[idx] : 32'h0;
    end

    // Wait counter: counts unanswered request cycles, saturating at GNT_DELAY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (!req_i || accept) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 2'(GNT_DELAY)) begin
            wait_cnt <= wait_cnt + 2'd1;
        end
    end

    // Outstanding count: up on accept, down on response, both = no change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst <= '0;
        end else begin
            case ({accept, rvalid_o})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: outst <= outst;
            endcase
        end
    end

    // Array write with byte enables; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response shift pipeline; stage 0 is loaded at the accepting edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_v <= '0;
            pipe_e <= '0;
            for (int i = 0; i < RESP_DELAY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= accept;
            pipe_e[0] <= accept && resp_err;
            pipe_d[0] <= accept ? resp_data : 32'h0;
            for (int i = 1; i < RESP_DELAY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    // Response outputs come from the pipeline head and are zero when idle.
    always_comb begin
        rvalid_o     = pipe_v[HD];
        rdata_o      = pipe_v[HD] ? pipe_d[HD] : 32'h0;
        err_o        = pipe_v[HD] && pipe_e[HD];
        rdata_intg_o = intg(rdata_o);
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with different grant/latency
// settings share the request payload signals; each has its own req and an
// in-order expected-response queue checked by a monitor.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        rst_n1;
  logic        req0, req1, req2;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [6:0]  wintg;

  logic        gnt0, gnt1, gnt2;
  logic        rvalid0, rvalid1, rvalid2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [6:0]  rintg0, rintg1, rintg2;
  logic        err0, err1, err2;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [32:0] exp_q2[$];

  // u0: immediate grant, single-cycle latency
  dmem_responder #(.GNT_DELAY(0), .RESP_DELAY(1), .MAX_OUTSTANDING(2)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg), .gnt_o(gnt0),
    .rvalid_o(rvalid0), .rdata_o(rdata0), .rdata_intg_o(rintg0), .err_o(err0));

  // u1: delayed grant, two-cycle latency, private reset
  dmem_responder #(.GNT_DELAY(3), .RESP_DELAY(2), .MAX_OUTSTANDING(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n1), .req_i(req1), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg), .gnt_o(gnt1),
    .rvalid_o(rvalid1), .rdata_o(rdata1), .rdata_intg_o(rintg1), .err_o(err1));

  // u2: immediate grant, three-cycle latency, outstanding limit 2
  dmem_responder #(.GNT_DELAY(0), .RESP_DELAY(3), .MAX_OUTSTANDING(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .wdata_intg_i(wintg), .gnt_o(gnt2),
    .rvalid_o(rvalid2), .rdata_o(rdata2), .rdata_intg_o(rintg2), .err_o(err2));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [6:0] ref_intg(input logic [31:0] d);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      for (int j = i; j < 32; j += 7) r[i] = r[i] ^ d[j];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic gnt_of(input int u);
    return (u == 0) ? gnt0 : (u == 1) ? gnt1 : gnt2;
  endfunction

  task automatic set_req(input int u, input logic v);
    case (u)
      0: req0 = v;
      1: req1 = v;
      default: req2 = v;
    endcase
  endtask

  task automatic push_exp(input int u, input logic [32:0] e);
    case (u)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // ---------------- driver ----------------
  // Drives one request on instance u; returns just after the accepting edge.
  task automatic issue(input int u, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [6:0] di, input logic [32:0] e,
                       input bit push, output int waited);
    @(posedge clk); #1;
    we = w; be = b; addr = a; wdata = d; wintg = di;
    set_req(u, 1'b1);
    waited = 0;
    @(negedge clk);
    while (!gnt_of(u) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!gnt_of(u)) chk("grant_timeout", 0, 1);
    else if (push) push_exp(u, e);
    @(posedge clk); #1;
    set_req(u, 1'b0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (rvalid0) begin
      if (exp_q0.size() == 0) chk("u0_unexpected_rvalid", 1, 0);
      else begin
        e = exp_q0.pop_front();
        chk("u0_rdata", rdata0, e[31:0]);
        chk("u0_err", err0, e[32]);
        chk("u0_rdata_intg", rintg0, ref_intg(e[31:0]));
      end
    end else begin
      chk("u0_idle_outputs_zero", {err0, rintg0, rdata0}, 0);
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rvalid1) begin
      if (exp_q1.size() == 0) chk("u1_unexpected_rvalid", 1, 0);
      else begin
        e = exp_q1.pop_front();
        chk("u1_rdata", rdata1, e[31:0]);
        chk("u1_err", err1, e[32]);
        chk("u1_rdata_intg", rintg1, ref_intg(e[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (rvalid2) begin
      if (exp_q2.size() == 0) chk("u2_unexpected_rvalid", 1, 0);
      else begin
        e = exp_q2.pop_front();
        chk("u2_rdata", rdata2, e[31:0]);
        chk("u2_err", err2, e[32]);
        chk("u2_rdata_intg", rintg2, ref_intg(e[31:0]));
      end
    end
  end

  // ---------------- test ----------------
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          bad;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int waited;
    logic [6:0] di;
    logic [31:0] u2_data[4];
    bit pat[6];
    int k;

    tbl[0]  = '{1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 4'h0, 32'h10,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 4'hF, 32'h20,   32'h11223344, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 4'h5, 32'h20,   32'hAABBCCDD, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 4'hF, 32'h20,   32'h0,        1'b0, 1'b0, 32'h11BB33DD};
    tbl[5]  = '{1'b0, 4'hF, 32'h1000, 32'h0,        1'b0, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 4'hF, 32'h30,   32'h12345678, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 4'hF, 32'h30,   32'h00000000, 1'b1, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 4'h0, 32'h30,   32'h0,        1'b0, 1'b0, 32'h12345678};
    tbl[9]  = '{1'b1, 4'h0, 32'h10,   32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 4'h0, 32'h13,   32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 4'hF, 32'hFFC,  32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 4'h0, 32'hFFC,  32'h0,        1'b0, 1'b0, 32'hCAFEF00D};
    tbl[13] = '{1'b1, 4'hF, 32'h1000, 32'h01020304, 1'b0, 1'b1, 32'h0};

    rst_n = 1'b0; rst_n1 = 1'b0;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; wintg = 7'h0;

    repeat (2) @(negedge clk);
    chk("reset_u0_outputs", {gnt0, rvalid0, err0, rintg0, rdata0}, 0);
    chk("reset_u1_outputs", {gnt1, rvalid1, err1, rintg1, rdata1}, 0);
    chk("reset_u2_outputs", {gnt2, rvalid2, err2, rintg2, rdata2}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst_n1 = 1'b1;

    // Table-driven single transactions on u0.
    for (int i = 0; i < 14; i++) begin
      di = tbl[i].bad ? (ref_intg(tbl[i].wdata) ^ 7'h01) : ref_intg(tbl[i].wdata);
      issue(0, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, di,
            {tbl[i].err, tbl[i].rdata}, 1'b1, waited);
      chk("u0_gnt_same_cycle", waited, 0);
      @(negedge clk);
      chk("u0_rvalid_after_one_cycle", rvalid0, 1);
      @(negedge clk);
      chk("u0_rvalid_one_cycle_only", rvalid0, 0);
    end

    // Back-to-back reads on u0 give back-to-back ordered responses.
    @(posedge clk); #1;
    we = 1'b0; be = 4'hF; addr = 32'h10; req0 = 1'b1;
    @(negedge clk);
    chk("b2b_gnt_first", gnt0, 1);
    exp_q0.push_back({1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    addr = 32'h20;
    @(negedge clk);
    chk("b2b_gnt_second", gnt0, 1);
    chk("b2b_rvalid_first", rvalid0, 1);
    exp_q0.push_back({1'b0, 32'h11BB33DD});
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("b2b_rvalid_second", rvalid0, 1);

    // u1: grant appears in the fourth cycle of a held request.
    @(posedge clk); #1;
    we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h5A5AA5A5;
    wintg = ref_intg(32'h5A5AA5A5); req1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("u1_gnt_delay", gnt1, (c == 3));
      if (gnt1) exp_q1.push_back({1'b0, 32'h0});
      @(posedge clk); #1;
    end
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // u1: dropping req in cycle 1 restarts the grant count.
    we = 1'b0; addr = 32'h40; req1 = 1'b1;
    @(negedge clk);
    chk("u1_restart_c0", gnt1, 0);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    chk("u1_restart_c1", gnt1, 0);
    @(posedge clk); #1;
    req1 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("u1_restart_gnt", gnt1, (c == 3));
      if (gnt1) exp_q1.push_back({1'b0, 32'h5A5AA5A5});
      @(posedge clk); #1;
    end
    req1 = 1'b0;
    repeat (4) @(negedge clk);

    // u1: reset one cycle after a read is accepted drops the response.
    issue(1, 1'b0, 4'hF, 32'h40, 32'h0, 7'h0, 33'h0, 1'b0, waited);
    rst_n1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("u1_in_reset_outputs", {gnt1, rvalid1, err1, rintg1, rdata1}, 0);
    end
    @(posedge clk); #1;
    rst_n1 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("u1_no_rvalid_after_reset", rvalid1, 0);
    end
    issue(1, 1'b0, 4'hF, 32'h40, 32'h0, 7'h0, {1'b0, 32'h5A5AA5A5}, 1'b1, waited);
    chk("u1_post_reset_gnt_wait", waited, 3);
    repeat (4) @(negedge clk);

    // u2: preload four words.
    for (int i = 0; i < 4; i++) begin
      u2_data[i] = 32'h1000_0000 + 32'($urandom_range(0, 32'h00FF_FFFF));
      issue(2, 1'b1, 4'hF, 32'h50 + 32'(4 * i), u2_data[i], ref_intg(u2_data[i]),
            33'h0, 1'b1, waited);
    end
    repeat (6) @(negedge clk);

    // u2: four held reads against an outstanding limit of two.
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0;
    pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b1;
    k = 0;
    @(posedge clk); #1;
    we = 1'b0; be = 4'hF; addr = 32'h50; req2 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("u2_gnt_pattern", gnt2, pat[c]);
      if (c == 3) chk("u2_first_rvalid_cycle3", rvalid2, 1);
      if (gnt2 && k < 4) begin
        exp_q2.push_back({1'b0, u2_data[k]});
        k++;
      end
      @(posedge clk); #1;
      addr = 32'h50 + 32'(4 * k);
      if (k == 4) req2 = 1'b0;
    end
    req2 = 1'b0;

    repeat (10) @(negedge clk);
    chk("u0_queue_drained", exp_q0.size(), 0);
    chk("u1_queue_drained", exp_q1.size(), 0);
    chk("u2_queue_drained", exp_q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
